// File: rtl/fpu_conv_d2h_pipe_if.sv
// fpu_conv_d2h_pipe_if
// Bundles the handshake and data signals of the double-to-half converter.
//   hold      : pipeline-wide stall
//   iValid    : source operand valid
//   regValFRm : Binary64 source operand
//   rndMode   : 0 = round-to-nearest-even, 1 = truncate toward zero
//   oValid    : result valid
//   regValFRn : Binary16 result
//   oFlags    : {inexact, underflow, overflow}
// master = producer of operands / consumer of results, slave = the converter.
interface fpu_conv_d2h_pipe_if;
  logic        hold;
  logic        iValid;
  logic [63:0] regValFRm;
  logic        rndMode;
  logic        oValid;
  logic [15:0] regValFRn;
  logic [2:0]  oFlags;

  modport master (
    output hold, iValid, regValFRm, rndMode,
    input  oValid, regValFRn, oFlags
  );

  modport slave (
    input  hold, iValid, regValFRm, rndMode,
    output oValid, regValFRn, oFlags
  );
endinterface

// File: rtl/fpu_conv_d2h_pipe.sv
// fpu_conv_d2h_pipe
// Two-stage Binary64 -> Binary16 converter.
// Stage 1 unpacks and classifies the operand; stage 2 rounds and packs.
// Results whose magnitude falls below the half normal range flush to zero.
// Ports:
//   clock : core clock, rising edge
//   reset : synchronous active-high reset (wins over hold)
//   bus   : fpu_conv_d2h_pipe_if.slave (hold, iValid, regValFRm, rndMode,
//           oValid, regValFRn, oFlags)
module fpu_conv_d2h_pipe (
  input  logic                  clock,
  input  logic                  reset,
  fpu_conv_d2h_pipe_if.slave    bus
);

  typedef enum logic [2:0] {
    CLS_ZERO  = 3'd0,
    CLS_INF   = 3'd1,
    CLS_NAN   = 3'd2,
    CLS_FLUSH = 3'd3,
    CLS_BIG   = 3'd4,
    CLS_NORM  = 3'd5
  } cls_e;

  // Double exponents 1..1008 are below the half normal range and
  // 1039 and above are beyond it.
  function automatic cls_e classify(input logic [10:0] e, input logic [51:0] m);
    cls_e c;
    if (e == 11'd0) begin
      c = CLS_ZERO;
    end else if (e == 11'h7FF) begin
      c = (m == 52'd0) ? CLS_INF : CLS_NAN;
    end else if (e <= 11'd1008) begin
      c = CLS_FLUSH;
    end else if (e >= 11'd1039) begin
      c = CLS_BIG;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  // Stage 1 unpack
  logic [10:0] in_exp_s;
  logic [51:0] in_man_s;
  logic [4:0]  in_eh_s;

  assign in_exp_s = bus.regValFRm[62:52];
  assign in_man_s = bus.regValFRm[51:0];
  // e - 1008 modulo 32: 1008 = 31*32 + 16, so only the low five bits matter.
  assign in_eh_s  = in_exp_s[4:0] - 5'd16;

  logic        s1_valid_r;
  logic        s1_sign_r;
  cls_e        s1_cls_r;
  logic [4:0]  s1_eh_r;
  logic [9:0]  s1_mh_r;
  logic        s1_lsb_r;
  logic        s1_guard_r;
  logic        s1_sticky_r;
  logic        s1_rnd_r;
  logic        s1_nz_r;

  // Stage 1 register: capture the classified operand when not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_cls_r    <= CLS_ZERO;
      s1_eh_r     <= 5'd0;
      s1_mh_r     <= 10'd0;
      s1_lsb_r    <= 1'b0;
      s1_guard_r  <= 1'b0;
      s1_sticky_r <= 1'b0;
      s1_rnd_r    <= 1'b0;
      s1_nz_r     <= 1'b0;
    end else if (!bus.hold) begin
      s1_valid_r  <= bus.iValid;
      s1_sign_r   <= bus.regValFRm[63];
      s1_cls_r    <= classify(in_exp_s, in_man_s);
      s1_eh_r     <= in_eh_s;
      s1_mh_r     <= in_man_s[51:42];
      s1_lsb_r    <= in_man_s[42];
      s1_guard_r  <= in_man_s[41];
      s1_sticky_r <= |in_man_s[40:0];
      s1_rnd_r    <= bus.rndMode;
      s1_nz_r     <= |in_man_s;
    end else begin
      s1_valid_r  <= s1_valid_r;
    end
  end

  // Stage 2 round: a mantissa carry ripples naturally into the exponent field.
  logic        inc_s;
  logic [14:0] sum_s;
  logic        inexact_s;

  assign inc_s     = ~s1_rnd_r & s1_guard_r & (s1_sticky_r | s1_lsb_r);
  assign sum_s     = {s1_eh_r, s1_mh_r} + {14'd0, inc_s};
  assign inexact_s = s1_guard_r | s1_sticky_r;

  logic [15:0] res_s;
  logic [2:0]  flags_s;

  // Stage 2 pack: select result and flags by operand class.
  always_comb begin
    res_s   = 16'h0000;
    flags_s = 3'b000;
    case (s1_cls_r)
      CLS_NORM: begin
        if (sum_s[14:10] == 5'h1F) begin
          res_s   = {s1_sign_r, 5'h1F, 10'h000};
          flags_s = {inexact_s, 1'b0, 1'b1};
        end else begin
          res_s   = {s1_sign_r, sum_s};
          flags_s = {inexact_s, 1'b0, 1'b0};
        end
      end
      CLS_BIG: begin
        res_s   = {s1_sign_r, (s1_rnd_r ? 15'h7BFF : 15'h7C00)};
        flags_s = 3'b101;
      end
      CLS_FLUSH: begin
        res_s   = {s1_sign_r, 15'h0000};
        flags_s = 3'b110;
      end
      CLS_ZERO: begin
        res_s   = {s1_sign_r, 15'h0000};
        flags_s = s1_nz_r ? 3'b110 : 3'b000;
      end
      CLS_INF: begin
        res_s   = {s1_sign_r, 15'h7C00};
        flags_s = 3'b000;
      end
      CLS_NAN: begin
        // Quiet the NaN and keep the upper payload bits.
        res_s   = {s1_sign_r, 5'h1F, 1'b1, s1_mh_r[8:0]};
        flags_s = 3'b000;
      end
      default: begin
        res_s   = 16'h0000;
        flags_s = 3'b000;
      end
    endcase
  end

  logic        out_valid_r;
  logic [15:0] out_res_r;
  logic [2:0]  out_flags_r;

  // Stage 2 register: publish the packed result when not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_res_r   <= 16'h0000;
      out_flags_r <= 3'b000;
    end else if (!bus.hold) begin
      out_valid_r <= s1_valid_r;
      out_res_r   <= res_s;
      out_flags_r <= flags_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.oValid    = out_valid_r;
  assign bus.regValFRn = out_res_r;
  assign bus.oFlags    = out_flags_r;

endmodule

// File: tb/tb_fpu_conv_d2h_pipe.sv
// tb_fpu_conv_d2h_pipe
// Self-checking bench for fpu_conv_d2h_pipe: directed vector table, stream
// with hold, reset discard, and a randomized run against a numeric model.
module tb_fpu_conv_d2h_pipe;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fpu_conv_d2h_pipe_if bus();

  fpu_conv_d2h_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Numeric model: returns {result[15:0], flags[2:0]}. Works on the real
  // exponent and the 53-bit significand rather than on half bit fields.
  function automatic logic [18:0] ref_d2h(input logic [63:0] x, input logic rnd);
    logic        s;
    int          e;
    int          ue;
    logic [51:0] m;
    logic [63:0] sig;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] half;
    logic [4:0]  ex;
    logic        inexact;
    s = x[63];
    e = int'(x[62:52]);
    m = x[51:0];
    if (e == 2047) begin
      if (m == 52'd0) return {s, 15'h7C00, 3'b000};
      return {s, 5'h1F, 1'b1, m[50:42], 3'b000};
    end
    if (e == 0) return {s, 15'h0000, ((m != 52'd0) ? 3'b110 : 3'b000)};
    ue = e - 1023;
    if (ue < -14) return {s, 15'h0000, 3'b110};
    if (ue > 15)  return {s, (rnd ? 15'h7BFF : 15'h7C00), 3'b101};
    sig  = {11'd0, 1'b1, m};
    q    = sig >> 42;
    half = 64'd1 << 41;
    r    = sig & ((64'd1 << 42) - 64'd1);
    inexact = (r != 64'd0);
    if (!rnd && ((r > half) || ((r == half) && q[0]))) q = q + 64'd1;
    if (q == 64'd2048) begin
      q  = 64'd1024;
      ue = ue + 1;
    end
    if (ue > 15) return {s, 15'h7C00, inexact, 2'b01};
    ex = 5'(ue + 15);
    return {s, ex, q[9:0], inexact, 2'b00};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] t;
    logic [51:0] m;
    logic [10:0] e;
    int          k;
    t = {$urandom, $urandom};
    m = t[51:0];
    k = int'($urandom_range(0, 9));
    case (k)
      0:       e = 11'd0;
      1:       e = 11'h7FF;
      2:       e = 11'($urandom_range(1, 1008));
      default: e = 11'($urandom_range(1000, 1045));
    endcase
    if ($urandom_range(0, 3) == 0) m[40:0] = 41'd0;
    if ($urandom_range(0, 7) == 0) m = 52'd0;
    return {1'($urandom), e, m};
  endfunction

  // Behavioural delay line: two un-held edges from input to output.
  logic [19:0] slot1 = 20'd0;
  logic [19:0] slot2 = 20'd0;
  logic        chk_en = 1'b0;
  logic        collect = 1'b0;
  logic        last_unheld = 1'b0;
  logic [15:0] got[$];

  always @(posedge clock) begin
    last_unheld <= !bus.hold && !reset;
    if (reset) begin
      slot1 <= 20'd0;
      slot2 <= 20'd0;
    end else if (!bus.hold) begin
      slot2 <= slot1;
      slot1 <= {bus.iValid, ref_d2h(bus.regValFRm, bus.rndMode)};
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_ovalid", 32'(bus.oValid), 32'(slot2[19]));
      if (slot2[19]) begin
        check("model_result", 32'(bus.regValFRn), 32'(slot2[18:3]));
        check("model_flags", 32'(bus.oFlags), 32'(slot2[2:0]));
      end
    end
    if (collect && last_unheld && bus.oValid) got.push_back(bus.regValFRn);
  end

  typedef struct {
    logic [63:0] x;
    logic        rnd;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  logic [63:0] ops[4];
  logic [16:0] snap;

  initial begin
    vecs[0]  = '{64'h3FF0000000000000, 1'b0, 16'h3C00, 3'b000};
    vecs[1]  = '{64'hC0EFFC0000000000, 1'b0, 16'hFBFF, 3'b000};
    vecs[2]  = '{64'h40EFFE0000000000, 1'b0, 16'h7C00, 3'b101};
    vecs[3]  = '{64'h40EFFE0000000000, 1'b1, 16'h7BFF, 3'b100};
    vecs[4]  = '{64'h3FF0020000000000, 1'b0, 16'h3C00, 3'b100};
    vecs[5]  = '{64'h3FF0060000000000, 1'b0, 16'h3C02, 3'b100};
    vecs[6]  = '{64'h3EB0000000000000, 1'b0, 16'h0000, 3'b110};
    vecs[7]  = '{64'h7FF0000000000000, 1'b0, 16'h7C00, 3'b000};
    vecs[8]  = '{64'h7FF0000000000001, 1'b0, 16'h7E00, 3'b000};
    vecs[9]  = '{64'h8000000000000000, 1'b0, 16'h8000, 3'b000};
    vecs[10] = '{64'h0000000000000001, 1'b0, 16'h0000, 3'b110};
    vecs[11] = '{64'hC7E0000000000000, 1'b0, 16'hFC00, 3'b101};
    vecs[12] = '{64'h47E0000000000000, 1'b1, 16'h7BFF, 3'b101};
    vecs[13] = '{64'h3F10000000000000, 1'b0, 16'h0400, 3'b000};
    vecs[14] = '{64'h3FF0020000000001, 1'b0, 16'h3C01, 3'b100};
    vecs[15] = '{64'h3FF0020000000001, 1'b1, 16'h3C00, 3'b100};
    vecs[16] = '{64'hFFF8000000000000, 1'b1, 16'hFE00, 3'b000};
    vecs[17] = '{64'h3F0FFFFFFFFFFFFF, 1'b0, 16'h0000, 3'b110};

    reset         = 1'b1;
    bus.hold      = 1'b0;
    bus.iValid    = 1'b0;
    bus.regValFRm = 64'd0;
    bus.rndMode   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ovalid", 32'(bus.oValid), 32'd0);
    check("reset_result", 32'(bus.regValFRn), 32'd0);
    check("reset_flags", 32'(bus.oFlags), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Directed table: one operand, result two edges later.
    for (int i = 0; i < NV; i++) begin
      bus.iValid    = 1'b1;
      bus.regValFRm = vecs[i].x;
      bus.rndMode   = vecs[i].rnd;
      @(negedge clock);
      bus.iValid = 1'b0;
      @(negedge clock);
      check($sformatf("vec%0d_ovalid", i), 32'(bus.oValid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'(bus.regValFRn), 32'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 32'(bus.oFlags), 32'(vecs[i].flg));
    end
    @(negedge clock);

    // Stream of four operands with hold high during the third and fourth cycles.
    ops[0] = 64'h3FF0000000000000;
    ops[1] = 64'hC0EFFC0000000000;
    ops[2] = 64'h40EFFE0000000000;
    ops[3] = 64'h3FF0060000000000;
    got.delete();
    collect       = 1'b1;
    bus.rndMode   = 1'b0;
    bus.iValid    = 1'b1;
    bus.regValFRm = ops[0];
    @(negedge clock);
    bus.regValFRm = ops[1];
    @(negedge clock);
    snap          = {bus.oValid, bus.regValFRn};
    bus.regValFRm = ops[2];
    bus.hold      = 1'b1;
    @(negedge clock);
    check("hold1_frozen", 32'({bus.oValid, bus.regValFRn}), 32'(snap));
    @(negedge clock);
    check("hold2_frozen", 32'({bus.oValid, bus.regValFRn}), 32'(snap));
    bus.hold = 1'b0;
    @(negedge clock);
    bus.regValFRm = ops[3];
    @(negedge clock);
    bus.iValid = 1'b0;
    repeat (3) @(negedge clock);
    collect = 1'b0;
    check("stream_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        check($sformatf("stream%0d_result", i), 32'(got[i]), 32'(ref_d2h(ops[i], 1'b0) >> 3));
      end else begin
        check($sformatf("stream%0d_missing", i), 32'd0, 32'd1);
      end
    end

    // Reset one cycle after issue discards the operation.
    bus.iValid    = 1'b1;
    bus.regValFRm = 64'h3FF0000000000000;
    @(negedge clock);
    bus.iValid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_ovalid", i), 32'(bus.oValid), 32'd0);
      check($sformatf("rst%0d_result", i), 32'(bus.regValFRn), 32'd0);
      check($sformatf("rst%0d_flags", i), 32'(bus.oFlags), 32'd0);
      @(negedge clock);
    end

    // Reset together with hold clears a completed result.
    bus.iValid    = 1'b1;
    bus.regValFRm = 64'hC0EFFC0000000000;
    @(negedge clock);
    bus.iValid = 1'b0;
    @(negedge clock);
    reset    = 1'b1;
    bus.hold = 1'b1;
    @(negedge clock);
    check("rsthold_ovalid", 32'(bus.oValid), 32'd0);
    check("rsthold_result", 32'(bus.regValFRn), 32'd0);
    check("rsthold_flags", 32'(bus.oFlags), 32'd0);
    reset    = 1'b0;
    bus.hold = 1'b0;
    @(negedge clock);

    // Randomized traffic with bubbles and stalls.
    for (int c = 0; c < 600; c++) begin
      bus.hold = ($urandom_range(0, 4) == 0);
      if (!bus.hold) begin
        bus.iValid    = ($urandom_range(0, 3) != 0);
        bus.regValFRm = rand_op();
        bus.rndMode   = 1'($urandom);
      end
      @(negedge clock);
    end
    bus.hold   = 1'b0;
    bus.iValid = 1'b0;
    repeat (3) @(negedge clock);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_conv_d2h_pipe.md
# fpu_conv_d2h_pipe

Pipelined double-to-half (Binary64 to Binary16) converter for the FPU store and convert path. It is the inverse of the combinational half-to-double widening unit. Rounding and range reduction make it too deep for one cycle, so it is split into two registered stages with valid tracking and a pipeline-wide hold. Subnormal results flush to zero, consistent with the rest of the FPU.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hold`  in  1  stall: when high, every pipeline register keeps its value.
- `iValid`  in  1  the input operand is valid this cycle.
- `regValFRm`  in  64  Binary64 source operand.
- `rndMode`  in  1  rounding mode: 0 = round-to-nearest-even, 1 = truncate toward zero.
- `oValid`  out  1  `regValFRn` and `oFlags` hold a completed result.
- `regValFRn`  out  16  Binary16 result.
- `oFlags`  out  3  {inexact, underflow, overflow}.

## Operation
Stage 1 (unpack and classify) registers:
- sign `s`, exponent `e = regValFRm[62:52]`, mantissa `m = regValFRm[51:0]`, `rndMode`, `iValid`.
- class, one of:
  - ZERO: `e==0`. Double subnormals are treated as zero; underflow is set if `m!=0`.
  - INF: `e==0x7FF`, `m==0`.
  - NAN: `e==0x7FF`, `m!=0`.
  - FLUSH: `1<=e<=1008`.
  - BIG: `e>=1039`.
  - NORM: otherwise.
- rebiased exponent `eh = e-1008`, 5 bits, meaningful only for NORM.
- `lsb = m[42]`, `guard = m[41]`, `sticky = |m[40:0]`, `mh = m[51:42]`.

Stage 2 (round and pack):
- RNE increment: `inc = guard & (sticky | lsb)`. Truncate: `inc = 0`.
- `{eh',mh'} = {eh,mh} + inc`, an 15-bit add. A mantissa carry propagates into the exponent.
- NORM with `eh'==31`: overflow, result `{s,5'h1F,10'h0}`.
- NORM otherwise: result `{s,eh',mh'}`. Inexact = `guard|sticky`.
- BIG:
  - RNE: `{s,0x7C00}`, overflow=1, inexact=1.
  - Truncate: `{s,0x7BFF}` (max finite), overflow=1, inexact=1.
- FLUSH: `{s,15'h0}`, underflow=1, inexact=1.
- ZERO: `{s,15'h0}`. Underflow and inexact are set only for a double subnormal input.
- INF: `{s,0x7C00}`, no flags.
- NAN: `{s,5'h1F,1'b1,m[50:42]}` (quieted, payload kept), no flags. The rounding increment is ignored.

Flags accompany their result. They are not sticky; accumulation happens in the FPU status logic.

## Timing
- Latency is exactly 2 un-held cycles. An operand accepted on edge N (`iValid=1`, `hold=0`) appears on `oValid`, `regValFRn`, and `oFlags` after edge N+1.
- Throughput is one operand per cycle. A back-to-back stream produces a back-to-back output.
- `hold=1`:
  - Both stages freeze, including `oValid`.
  - Inputs presented during hold are ignored, not queued. The upstream must keep them stable until the hold drops.
- Bubbles: `iValid=0` propagates as `oValid=0`. Data registers may update freely, but `regValFRn` and `oFlags` are don't-care while `oValid=0`.
- Reset:
  - Effective on an edge even if `hold=1`.
  - Clears both valid bits. `oValid=0`, `regValFRn=16'h0000`, `oFlags=3'b000`.
  - An operation in flight at reset is discarded; no output is produced for it.
- `hold` and `reset` asserted together: reset wins.

## Test plan
- RNE, no hold:
  - 0x3FF0000000000000 -> 0x3C00, flags 000, 2 cycles later.
  - 0xC0EFFC0000000000 -> 0xFBFF, flags 000.
- 0x40EFFE0000000000 (65520):
  - RNE -> 0x7C00, flags 101 (mantissa carry into exponent 31).
  - Truncate -> 0x7BFF, flags 100.
- Ties, RNE:
  - 0x3FF0020000000000 -> 0x3C00, flags 100 (tie to even).
  - 0x3FF0060000000000 -> 0x3C02, flags 100.
- Specials:
  - 0x3EB0000000000000 (2^-20) -> 0x0000, flags 110.
  - 0x7FF0000000000000 -> 0x7C00, flags 000.
  - 0x7FF0000000000001 -> 0x7E00, flags 000.
  - 0x8000000000000000 -> 0x8000, flags 000.
- Stream and hold:
  - Stream of 4 operands, with `hold` high on cycles 2-3.
  - Outputs appear in order with no drop or duplicate.
  - `oValid` and data are frozen during the hold.
- Reset:
  - Assert `reset` one cycle after issuing an operand.
  - `oValid` stays 0 and the outputs read 0 on the following cycles.
